// File: rtl/ascon_perm_engine.sv
// ASCON permutation engine: xor-begin, pa/pb rounds (UNROLL per clock), xor-end.
// Define ASCON_ABORT_EN to add the abort_i cancel input.
module ascon_perm_engine #(
   parameter int UNROLL    = 1,
   parameter int RATE_BITS = 128
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
`ifdef ASCON_ABORT_EN
   input  logic                 abort_i,
`endif
   input  logic                 start_i,
   input  logic                 mode_i,
   input  logic                 load_i,
   input  logic [319:0]         state_i,
   input  logic                 xor_b_en_i,
   input  logic [RATE_BITS-1:0] data_i,
   input  logic [1:0]           xor_e_mode_i,
   input  logic [127:0]         key_i,
   input  logic                 cipher_en_i,
   input  logic                 tag_en_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [319:0]         state_o,
   output logic [127:0]         cipher_o,
   output logic [127:0]         tag_o
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
      $error("ascon_perm_engine: UNROLL must be 1, 2 or 4");
   end
   if (!(RATE_BITS == 64 || RATE_BITS == 128)) begin : g_bad_rate
      $error("ascon_perm_engine: RATE_BITS must be 64 or 128");
   end

   typedef enum logic {S_IDLE, S_RUN} fsm_e;

   localparam logic [3:0] STEP = 4'(UNROLL);
   localparam logic [3:0] LAST = 4'd12;

   fsm_e         fsm_q, fsm_d;
   logic [319:0] state_q, state_d;
   logic [127:0] cipher_q, cipher_d;
   logic [127:0] tag_q, tag_d;
   logic [3:0]   ctr_q, ctr_d;
   logic         done_q, done_d;
   logic [1:0]   xe_q, xe_d;
   logic [127:0] key_q, key_d;
   logic         ten_q, ten_d;

   logic         idle, go, last, ten_eff;
   logic [319:0] s0, r_in, r_out, fin;
   logic [3:0]   r_idx;
   logic [1:0]   xe_eff;
   logic [127:0] key_eff, cap;

   function automatic logic [319:0] round_f(input logic [319:0] s,
                                            input logic [3:0]   r);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      {x0, x1, x2, x3, x4} = s;
      x2[7:0] = x2[7:0] ^ {4'hF - r, r};
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
      x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
      x2 = x2 ^ {x2[0], x2[63:1]} ^ {x2[5:0], x2[63:6]};
      x3 = x3 ^ {x3[9:0], x3[63:10]} ^ {x3[16:0], x3[63:17]};
      x4 = x4 ^ {x4[6:0], x4[63:7]} ^ {x4[40:0], x4[63:41]};
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic logic [319:0] rounds_f(input logic [319:0] s,
                                             input logic [3:0]   r0);
      logic [319:0] t;
      t = s;
      for (int k = 0; k < UNROLL; k++) begin
         t = round_f(t, r0 + 4'(k));
      end
      return t;
   endfunction

   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      cipher_d = cipher_q;
      tag_d    = tag_q;
      ctr_d    = ctr_q;
      done_d   = 1'b0;
      xe_d     = xe_q;
      key_d    = key_q;
      ten_d    = ten_q;

      idle = (fsm_q == S_IDLE);
      s0   = load_i ? state_i : state_q;
      if (xor_b_en_i) begin
         s0[319 -: RATE_BITS] = s0[319 -: RATE_BITS] ^ data_i;
      end
      if (RATE_BITS == 64) begin
         cap = {s0[319:256], 64'h0};
      end else begin
         cap = s0[319:192];
      end

      // At the start edge the run's settings come straight from the ports.
      r_idx   = idle ? (mode_i ? 4'd4 : 4'd0) : ctr_q;
      r_in    = idle ? s0 : state_q;
      xe_eff  = idle ? xor_e_mode_i : xe_q;
      key_eff = idle ? key_i : key_q;
      ten_eff = idle ? tag_en_i : ten_q;

      r_out = rounds_f(r_in, r_idx);
      last  = (r_idx + STEP == LAST);
      fin   = r_out;
      if (xe_eff[0]) fin[127:0] = fin[127:0] ^ key_eff;
      if (xe_eff[1]) fin[0] = ~fin[0];

      unique case (fsm_q)
         S_IDLE:  go = start_i;
         S_RUN:   go = 1'b1;
         default: go = 1'b0;
      endcase

      if (go) begin
         fsm_d   = S_RUN;
         state_d = r_out;
         ctr_d   = r_idx + STEP;
         if (idle) begin
            xe_d  = xor_e_mode_i;
            key_d = key_i;
            ten_d = tag_en_i;
            if (cipher_en_i) cipher_d = cap;
         end
         if (last) begin
            fsm_d   = S_IDLE;
            done_d  = 1'b1;
            ctr_d   = 4'd0;
            state_d = fin;
            if (ten_eff) tag_d = fin[127:0];
         end
      end

`ifdef ASCON_ABORT_EN
      if (abort_i) begin
         fsm_d    = S_IDLE;
         state_d  = '0;
         cipher_d = '0;
         tag_d    = '0;
         ctr_d    = 4'd0;
         done_d   = 1'b0;
      end
`endif
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm_q    <= S_IDLE;
         state_q  <= '0;
         cipher_q <= '0;
         tag_q    <= '0;
         ctr_q    <= 4'd0;
         done_q   <= 1'b0;
         xe_q     <= 2'b00;
         key_q    <= '0;
         ten_q    <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         state_q  <= state_d;
         cipher_q <= cipher_d;
         tag_q    <= tag_d;
         ctr_q    <= ctr_d;
         done_q   <= done_d;
         xe_q     <= xe_d;
         key_q    <= key_d;
         ten_q    <= ten_d;
      end
   end

   assign busy_o   = (fsm_q == S_RUN);
   assign done_o   = done_q;
   assign state_o  = state_q;
   assign cipher_o = cipher_q;
   assign tag_o    = tag_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Scoreboard bench for ascon_perm_engine against a table-driven ASCON model.
module tb_ascon_perm_engine #(
   parameter int UNROLL = 1
);
   localparam int RB = 128;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
   localparam int ROT2 [5] = '{28, 39, 6, 17, 41};

   typedef struct {
      logic [319:0] st;
      logic [127:0] ci;
      logic [127:0] tg;
      int           ncyc;
      int           e0;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          abort_i = 1'b0;
   logic          start_i = 1'b1;
   logic          mode_i = 1'b0;
   logic          load_i = 1'b0;
   logic [319:0]  state_i = '0;
   logic          xor_b_en_i = 1'b0;
   logic [RB-1:0] data_i = '0;
   logic [1:0]    xor_e_mode_i = 2'b00;
   logic [127:0]  key_i = '0;
   logic          cipher_en_i = 1'b0;
   logic          tag_en_i = 1'b0;
   logic          busy_o, done_o;
   logic [319:0]  state_o;
   logic [127:0]  cipher_o, tag_o;

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            busy_cnt = 0;
   bit            zero_pend = 1'b0;
   exp_t          sb_q[$];
   logic [319:0]  m_state = '0;
   logic [127:0]  m_cipher = '0;
   logic [127:0]  m_tag = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ascon_perm_engine #(.UNROLL(UNROLL), .RATE_BITS(RB)) dut (
      .clock_i      (clk),
      .reset_i      (reset_i),
`ifdef ASCON_ABORT_EN
      .abort_i      (abort_i),
`endif
      .start_i      (start_i),
      .mode_i       (mode_i),
      .load_i       (load_i),
      .state_i      (state_i),
      .xor_b_en_i   (xor_b_en_i),
      .data_i       (data_i),
      .xor_e_mode_i (xor_e_mode_i),
      .key_i        (key_i),
      .cipher_en_i  (cipher_en_i),
      .tag_en_i     (tag_en_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .state_o      (state_o),
      .cipher_o     (cipher_o),
      .tag_o        (tag_o)
   );

   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Column-wise S-box lookup with x0 as the column MSB.
   function automatic logic [319:0] perm_ref(input logic [319:0] s, input bit pb);
      logic [63:0]  x [5];
      logic [63:0]  y [5];
      logic [4:0]   col, o;
      logic [319:0] res;
      for (int j = 0; j < 5; j++) x[j] = s[319 - 64*j -: 64];
      for (int r = pb ? 4 : 0; r < 12; r++) begin
         x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
         for (int i = 0; i < 64; i++) begin
            col = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
            o = SBOX[col];
            for (int j = 0; j < 5; j++) y[j][i] = o[4 - j];
         end
         for (int j = 0; j < 5; j++)
            x[j] = y[j] ^ ror(y[j], ROT1[j]) ^ ror(y[j], ROT2[j]);
      end
      res = '0;
      for (int j = 0; j < 5; j++) res[319 - 64*j -: 64] = x[j];
      return res;
   endfunction

   function automatic logic [319:0] rnd320();
      logic [319:0] v;
      v = '0;
      for (int i = 0; i < 10; i++) v = {v[287:0], 32'($urandom)};
      return v;
   endfunction

   task automatic chk(input string name, input logic [319:0] act,
                      input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic model_push(input int e0);
      exp_t e;
      logic [319:0] s;
      s = load_i ? state_i : m_state;
      if (xor_b_en_i) s[319:192] = s[319:192] ^ data_i;
      if (cipher_en_i) m_cipher = s[319:192];
      s = perm_ref(s, mode_i);
      if (xor_e_mode_i[0]) s[127:0] = s[127:0] ^ key_i;
      if (xor_e_mode_i[1]) s[0] = ~s[0];
      if (tag_en_i) m_tag = s[127:0];
      m_state = s;
      e.st = s;
      e.ci = m_cipher;
      e.tg = m_tag;
      e.ncyc = (mode_i ? 8 : 12) / UNROLL;
      e.e0 = e0;
      sb_q.push_back(e);
   endtask

   task automatic rand_inputs();
      mode_i       = 1'($urandom);
      load_i       = 1'($urandom);
      state_i      = rnd320();
      xor_b_en_i   = 1'($urandom);
      data_i       = {$urandom, $urandom, $urandom, $urandom};
      xor_e_mode_i = 2'($urandom);
      key_i        = {$urandom, $urandom, $urandom, $urandom};
      cipher_en_i  = 1'($urandom);
      tag_en_i     = 1'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic run_one();
      @(posedge clk); #1;
      start_i = 1'b1;
      model_push(cyc + 1);
      @(posedge clk); #1;
      start_i = 1'b0;
      wait_idle();
   endtask

   task automatic clear_model();
      m_state  = '0;
      m_cipher = '0;
      m_tag    = '0;
   endtask

   // Monitor: reset/abort zeroisation, done-driven scoreboard, watchdog.
   always @(negedge clk) begin
      exp_t e;
      if (zero_pend) begin
         chk("zero_busy", 320'(busy_o), 320'(0));
         chk("zero_done", 320'(done_o), 320'(0));
         chk("zero_state", state_o, 320'(0));
         chk("zero_cipher", 320'(cipher_o), 320'(0));
         chk("zero_tag", 320'(tag_o), 320'(0));
      end
      zero_pend = reset_i | abort_i;
      if (zero_pend) begin
         busy_cnt = 0;
         sb_q.delete();
      end else begin
         if (busy_o === 1'b1) busy_cnt++;
         if (done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 320'(1), 320'(0));
            end else begin
               e = sb_q.pop_front();
               chk("state", state_o, e.st);
               chk("cipher", 320'(cipher_o), 320'(e.ci));
               chk("tag", 320'(tag_o), 320'(e.tg));
               chk("latency", 320'(cyc - e.e0), 320'(e.ncyc - 1));
               chk("busy_cycles", 320'(busy_cnt), 320'(e.ncyc - 1));
               chk("busy_at_done", 320'(busy_o), 320'(0));
            end
            busy_cnt = 0;
         end else if (sb_q.size() != 0 && cyc - sb_q[0].e0 > 40) begin
            chk("done_timeout", 320'(0), 320'(1));
            void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      int e0, c, k;
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk);

      load_i = 1'b1;
      mode_i = 1'b0;
      state_i = '0;
      run_one();

      load_i = 1'b0;
      mode_i = 1'b1;
      xor_b_en_i = 1'b1;
      data_i = 128'h0123456789abcdef0123456789abcdef;
      cipher_en_i = 1'b1;
      run_one();

      load_i = 1'b1;
      mode_i = 1'b0;
      state_i = '0;
      xor_b_en_i = 1'b0;
      cipher_en_i = 1'b0;
      xor_e_mode_i = 2'b11;
      key_i = '1;
      tag_en_i = 1'b1;
      run_one();

      for (int n = 0; n < 20; n++) begin
         rand_inputs();
         run_one();
      end

      // start held high: four chained runs, starts while busy ignored
      @(posedge clk); #1;
      rand_inputs();
      load_i = 1'b0;
      start_i = 1'b1;
      e0 = cyc + 1;
      c = (mode_i ? 8 : 12) / UNROLL;
      for (int j = 0; j < 4; j++) model_push(e0 + j * c);
      do begin
         @(posedge clk); #1;
      end while (cyc < e0 + 4 * c - 1);
      start_i = 1'b0;
      wait_idle();

      // reset in the middle of a pa run
      rand_inputs();
      mode_i = 1'b0;
      k = (12 / UNROLL) / 2;
      @(posedge clk); #1;
      start_i = 1'b1;
      e0 = cyc + 1;
      model_push(e0);
      @(posedge clk); #1;
      start_i = 1'b0;
      while (cyc < e0 + k - 1) begin
         @(posedge clk); #1;
      end
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      clear_model();
      repeat (16) @(negedge clk);

`ifdef ASCON_ABORT_EN
      rand_inputs();
      mode_i = 1'b0;
      @(posedge clk); #1;
      start_i = 1'b1;
      e0 = cyc + 1;
      model_push(e0);
      @(posedge clk); #1;
      start_i = 1'b0;
      while (cyc < e0 + k - 1) begin
         @(posedge clk); #1;
      end
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
      clear_model();
      repeat (16) @(negedge clk);

      rand_inputs();
      @(posedge clk); #1;
      start_i = 1'b1;
      abort_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      abort_i = 1'b0;
      clear_model();
      repeat (16) @(negedge clk);
`endif

      rand_inputs();
      load_i = 1'b0;
      run_one();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
